// File: rtl/mem_pkg.sv
// Shared types for the main-memory responder: per-read routing tag and latency bound.
package mem_pkg;

  typedef struct packed {
    logic       reload;
    logic [1:0] choice;
    logic       conveyor;
    logic       dstack;
    logic       stream;
  } mem_rd_tag_t;

  localparam int unsigned MEM_MAX_READ_LATENCY = 8;

  function automatic logic tag_any_kind(input mem_rd_tag_t t);
    return t.reload | t.conveyor | t.dstack | t.stream;
  endfunction

  // True when two or more read kinds are requested in the same cycle.
  function automatic logic tag_kind_conflict(input mem_rd_tag_t t);
    return (t.reload   & (t.conveyor | t.dstack | t.stream)) |
           (t.conveyor & (t.dstack | t.stream)) |
           (t.dstack   & t.stream);
  endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Delay line carrying {valid, tag, data} from the registered array read to the output port.
module mem_read_pipe
  import mem_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  mem_rd_tag_t           in_tag,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output mem_rd_tag_t           out_tag,
  output logic [WORD_WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_tag   = in_tag;
    assign out_data  = in_data;
  end else begin : g_shift
    logic        [STAGES-1:0]     valid_q;
    mem_rd_tag_t                  tag_q  [STAGES];
    logic        [WORD_WIDTH-1:0] data_q [STAGES];

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < STAGES; i++) tag_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        tag_q[0]   <= in_tag;
        for (int unsigned i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          tag_q[i]   <= tag_q[i-1];
        end
      end
    end

    // Data carries no reset; it is only meaningful alongside valid.
    always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int unsigned i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: word array with write-first read, fixed-latency tagged returns,
// in-flight counter, load-pacing feedback registers and a sticky protocol error flag.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MAIN_ADDR_WIDTH = 8,
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_out,
  input  logic [MAIN_ADDR_WIDTH-1:0] write_address,
  input  logic [WORD_WIDTH-1:0]      write_value,
  input  logic [MAIN_ADDR_WIDTH-1:0] read_address,
  input  logic                       reload,
  input  logic [1:0]                 choice,
  input  logic                       conveyor_memload,
  input  logic                       dstack_memload,
  input  logic                       stream_read,
  output logic [WORD_WIDTH-1:0]      read_value,
  output logic                       dc_valid,
  output logic [1:0]                 dc_choice,
  output logic                       conveyor_valid,
  output logic                       dstack_valid,
  output logic                       stream_valid,
  output logic                       conveyor_memload_last,
  output logic                       dstack_memload_last,
  output logic [3:0]                 inflight,
  output logic                       protocol_error
);

  localparam int unsigned DEPTH = 2 ** MAIN_ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  mem_rd_tag_t           issue_tag;
  logic                  issue;
  logic [WORD_WIDTH-1:0] issue_data;

  logic                  s0_valid;
  mem_rd_tag_t           s0_tag;
  logic [WORD_WIDTH-1:0] s0_data;

  logic                  ret_valid;
  mem_rd_tag_t           ret_tag;
  logic [WORD_WIDTH-1:0] ret_data;

  // Choice is only captured alongside a reload so dc_choice stays 0 otherwise.
  always_comb begin
    issue_tag          = '0;
    issue_tag.reload   = reload;
    issue_tag.choice   = reload ? choice : 2'b00;
    issue_tag.conveyor = conveyor_memload;
    issue_tag.dstack   = dstack_memload;
    issue_tag.stream   = stream_read;
    issue              = tag_any_kind(issue_tag);
  end

  // Write-first: a same-cycle write to the read address is forwarded to the read.
  always_comb begin
    issue_data = mem[read_address];
    if (write_out && (write_address == read_address)) issue_data = write_value;
  end

  always_ff @(posedge clk) begin
    if (write_out) mem[write_address] <= write_value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_tag   <= '0;
    end else begin
      s0_valid <= issue;
      s0_tag   <= issue ? issue_tag : '0;
    end
  end

  always_ff @(posedge clk) begin
    s0_data <= issue_data;
  end

  mem_read_pipe #(
    .WORD_WIDTH (WORD_WIDTH),
    .STAGES     (READ_LATENCY - 1)
  ) u_read_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s0_valid),
    .in_tag    (s0_tag),
    .in_data   (s0_data),
    .out_valid (ret_valid),
    .out_tag   (ret_tag),
    .out_data  (ret_data)
  );

  assign read_value     = ret_data;
  assign dc_valid       = ret_valid & ret_tag.reload;
  assign dc_choice      = ret_tag.choice;
  assign conveyor_valid = ret_valid & ret_tag.conveyor;
  assign dstack_valid   = ret_valid & ret_tag.dstack;
  assign stream_valid   = ret_valid & ret_tag.stream;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      unique case ({issue, ret_valid})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conveyor_memload_last <= 1'b0;
      dstack_memload_last   <= 1'b0;
      protocol_error        <= 1'b0;
    end else begin
      conveyor_memload_last <= conveyor_memload;
      dstack_memload_last   <= dstack_memload;
      if (tag_kind_conflict(issue_tag)) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: directed scenarios with literal expectations plus a random run
// checked every cycle against a cycle-indexed behavioural model of returns.
module tb_main_mem_responder;

  localparam int unsigned MAW = 8;
  localparam int unsigned WW  = 32;
  localparam int unsigned LAT = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           write_out;
  logic [MAW-1:0] write_address;
  logic [WW-1:0]  write_value;
  logic [MAW-1:0] read_address;
  logic           reload;
  logic [1:0]     choice;
  logic           conveyor_memload;
  logic           dstack_memload;
  logic           stream_read;
  logic [WW-1:0]  read_value;
  logic           dc_valid;
  logic [1:0]     dc_choice;
  logic           conveyor_valid;
  logic           dstack_valid;
  logic           stream_valid;
  logic           conveyor_memload_last;
  logic           dstack_memload_last;
  logic [3:0]     inflight;
  logic           protocol_error;

  always #5 clk = ~clk;

  main_mem_responder #(
    .MAIN_ADDR_WIDTH (MAW),
    .WORD_WIDTH      (WW),
    .READ_LATENCY    (LAT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .write_out             (write_out),
    .write_address         (write_address),
    .write_value           (write_value),
    .read_address          (read_address),
    .reload                (reload),
    .choice                (choice),
    .conveyor_memload      (conveyor_memload),
    .dstack_memload        (dstack_memload),
    .stream_read           (stream_read),
    .read_value            (read_value),
    .dc_valid              (dc_valid),
    .dc_choice             (dc_choice),
    .conveyor_valid        (conveyor_valid),
    .dstack_valid          (dstack_valid),
    .stream_valid          (stream_valid),
    .conveyor_memload_last (conveyor_memload_last),
    .dstack_memload_last   (dstack_memload_last),
    .inflight              (inflight),
    .protocol_error        (protocol_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: results are filed under the cycle number in which they must appear.
  logic [WW-1:0] mem_m  [256];
  bit            due_v  [16];
  logic [3:0]    due_k  [16];
  logic [1:0]    due_ch [16];
  logic [WW-1:0] due_d  [16];
  int unsigned   cyc = 0;
  bit            started = 0;
  bit            err_m = 0;
  bit            conv_last_m = 0;
  bit            ds_last_m = 0;

  always @(negedge clk) begin
    int unsigned slot, s2, n;
    logic [3:0]  kinds;
    slot = cyc % 16;
    if (started) begin
      check("valids", {dc_valid, conveyor_valid, dstack_valid, stream_valid},
            due_v[slot] ? due_k[slot] : 4'b0000);
      if (due_v[slot]) check("read_value", read_value, due_d[slot]);
      if (due_v[slot] && due_k[slot][3]) check("dc_choice", dc_choice, due_ch[slot]);
      n = 0;
      for (int unsigned i = 0; i < LAT; i++) if (due_v[(cyc + i) % 16]) n++;
      check("inflight", inflight, n);
      check("conveyor_last", conveyor_memload_last, conv_last_m);
      check("dstack_last", dstack_memload_last, ds_last_m);
      check("protocol_error", protocol_error, err_m);
      due_v[slot] = 0;
    end
    if (reset) begin
      started = 1;
      for (int unsigned i = 0; i < 16; i++) due_v[i] = 0;
      err_m = 0;
      conv_last_m = 0;
      ds_last_m = 0;
    end else if (started) begin
      kinds = {reload, conveyor_memload, dstack_memload, stream_read};
      if (kinds != 4'b0000) begin
        s2 = (cyc + LAT) % 16;
        due_v[s2]  = 1;
        due_k[s2]  = kinds;
        due_ch[s2] = choice;
        due_d[s2]  = (write_out && write_address == read_address) ? write_value
                                                                   : mem_m[read_address];
        if ($countones(kinds) > 1) err_m = 1;
      end
      if (write_out) mem_m[write_address] = write_value;
      conv_last_m = conveyor_memload;
      ds_last_m   = dstack_memload;
    end
    cyc++;
  end

  // Advance to the next cycle with idle requests and random don't-care fields.
  task automatic tick();
    @(posedge clk);
    #1;
    reset            = 1'b0;
    write_out        = 1'b0;
    reload           = 1'b0;
    conveyor_memload = 1'b0;
    dstack_memload   = 1'b0;
    stream_read      = 1'b0;
    write_address    = MAW'($urandom);
    write_value      = WW'($urandom);
    read_address     = MAW'($urandom);
    choice           = 2'($urandom);
  endtask

  initial begin
    reset = 1'b1; write_out = 1'b0; reload = 1'b0; conveyor_memload = 1'b0;
    dstack_memload = 1'b0; stream_read = 1'b0; write_address = '0; write_value = '0;
    read_address = '0; choice = '0;
    repeat (3) @(posedge clk);
    tick();
    @(negedge clk);
    check("rst_valids", {dc_valid, conveyor_valid, dstack_valid, stream_valid}, 0);
    check("rst_dc_choice", dc_choice, 0);
    check("rst_inflight", inflight, 0);
    check("rst_perr", protocol_error, 0);
    check("rst_lasts", {conveyor_memload_last, dstack_memload_last}, 0);

    for (int unsigned a = 0; a < 256; a++) begin
      tick(); write_out = 1'b1; write_address = MAW'(a); write_value = WW'(32'h9E37_79B9 * a);
    end

    // 1: write then conveyor read, returns exactly two cycles after issue
    tick(); write_out = 1'b1; write_address = 8'd5; write_value = 32'h1234;
    tick(); conveyor_memload = 1'b1; read_address = 8'd5;
    tick(); @(negedge clk);
    check("t1_early", conveyor_valid, 0);
    check("t1_last", conveyor_memload_last, 1);
    tick(); @(negedge clk);
    check("t1_valid", conveyor_valid, 1);
    check("t1_data", read_value, 32'h1234);

    // 2: same-cycle write and reload to the same address
    tick(); write_out = 1'b1; write_address = 8'd7; write_value = 32'hBEEF;
    reload = 1'b1; choice = 2'd2; read_address = 8'd7;
    tick();
    tick(); @(negedge clk);
    check("t2_valid", dc_valid, 1);
    check("t2_choice", dc_choice, 2);
    check("t2_data", read_value, 32'hBEEF);

    // 3: later write does not disturb an in-flight read
    tick(); write_out = 1'b1; write_address = 8'd3; write_value = 32'h11;
    tick(); dstack_memload = 1'b1; read_address = 8'd3;
    tick(); write_out = 1'b1; write_address = 8'd3; write_value = 32'h22;
    tick(); @(negedge clk);
    check("t3_valid", dstack_valid, 1);
    check("t3_old", read_value, 32'h11);
    tick(); conveyor_memload = 1'b1; read_address = 8'd3;
    tick();
    tick(); @(negedge clk);
    check("t3_new", read_value, 32'h22);

    // 4: four back-to-back reads of different kinds
    tick(); conveyor_memload = 1'b1; read_address = 8'd5;
    tick(); dstack_memload = 1'b1; read_address = 8'd7;
    tick(); stream_read = 1'b1; read_address = 8'd3;
    @(negedge clk);
    check("t4_conv", {dc_valid, conveyor_valid, dstack_valid, stream_valid}, 4'b0100);
    check("t4_conv_data", read_value, 32'h1234);
    tick(); reload = 1'b1; choice = 2'd1; read_address = 8'd5;
    @(negedge clk);
    check("t4_inflight", inflight, 2);
    check("t4_dstack", {dc_valid, conveyor_valid, dstack_valid, stream_valid}, 4'b0010);
    check("t4_dstack_data", read_value, 32'hBEEF);
    tick(); @(negedge clk);
    check("t4_stream", {dc_valid, conveyor_valid, dstack_valid, stream_valid}, 4'b0001);
    check("t4_stream_data", read_value, 32'h22);
    tick(); @(negedge clk);
    check("t4_dc", {dc_valid, conveyor_valid, dstack_valid, stream_valid}, 4'b1000);
    check("t4_dc_choice", dc_choice, 1);

    // 5: reset one cycle after issue drops the read
    tick(); dstack_memload = 1'b1; read_address = 8'd3;
    tick(); reset = 1'b1;
    tick(); @(negedge clk);
    check("t5_valid", dstack_valid, 0);
    check("t5_inflight", inflight, 0);
    check("t5_last", dstack_memload_last, 0);
    tick(); @(negedge clk);
    check("t5_valid_late", dstack_valid, 0);

    // 6: two kinds at once
    tick(); conveyor_memload = 1'b1; dstack_memload = 1'b1; read_address = 8'd7;
    tick(); @(negedge clk);
    check("t6_perr", protocol_error, 1);
    tick(); @(negedge clk);
    check("t6_valids", {dc_valid, conveyor_valid, dstack_valid, stream_valid}, 4'b0110);
    check("t6_data", read_value, 32'hBEEF);
    repeat (3) tick();
    @(negedge clk);
    check("t6_sticky", protocol_error, 1);

    // Random traffic over a small address window to provoke hazards.
    repeat (3000) begin
      int unsigned k;
      tick();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
      end else begin
        read_address = MAW'($urandom_range(0, 15));
        write_out    = 1'($urandom_range(0, 1));
        write_address = ($urandom_range(0, 3) == 0) ? read_address : MAW'($urandom_range(0, 15));
        k = $urandom_range(0, 19);
        case (k)
          0, 1, 2, 3: ;
          4, 5, 6:    reload = 1'b1;
          7, 8, 9:    conveyor_memload = 1'b1;
          10, 11, 12: dstack_memload = 1'b1;
          13, 14, 15: stream_read = 1'b1;
          16, 17:     dstack_memload = 1'($urandom_range(0, 1));
          default: begin
            reload           = 1'($urandom_range(0, 1));
            conveyor_memload = 1'($urandom_range(0, 1));
            dstack_memload   = 1'($urandom_range(0, 1));
            stream_read      = 1'($urandom_range(0, 1));
          end
        endcase
      end
    end
    repeat (LAT + 2) tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
